proc_alu8: RTL
==============

Name: proc_alu8

Overview:
- Parametrised successor to the team's 9-bit multicycle bus processor.
- Data width is configurable via DW. The instruction set grows from mv/mvi/add/sub to eight opcodes: logic ops plus a conditional move on a zero flag.
- Eight general registers R0-R7, an A operand register and a G result register share one tri-state-free multiplexed bus.
- Sits behind the instruction/data source that drives DIN and Run; a four-step FSM (T0-T3) sequences each instruction.

Parameters:
- DW, 16, data/bus/register width in bits; must be >= 9. Instruction word is DIN[8:0], upper bits are ignored for the opcode.

Ports:
- Clock  input  1  system clock, all state updates on rising edge
- Resetn  input  1  asynchronous active-low reset
- Run  input  1  start request; sampled only in T0
- DIN  input  DW  instruction word in T0; immediate operand during mvi T1
- Done  output  1  high during the final step of every instruction
- BusWires  output  DW  current bus value
- Z  output  1  zero flag, high when the last G load was all-zero

Behaviour:
- Instruction format in IR[8:0]: I = IR[8:6], X = IR[5:3] (dest Rx), Y = IR[2:0] (source Ry).
- Opcodes: 000 mv, 001 mvi, 010 add, 011 sub, 100 and, 101 or, 110 xor, 111 mvnz.
- Reset (Resetn=0, async): R0-R7, A, G, IR = 0; Z = 1; FSM = T0; Done = 0. BusWires reads 0 while reset is held.
- Bus mux has exactly one source per step: Rx, Ry, DIN, G, or none. With no source, BusWires = 0.
- T0:
  - Run=0: stay in T0.
  - Run=1: IR <= DIN[8:0] on the clock edge, go to T1.
  - Run is ignored in T1-T3.
- T1:
  - mv: bus=Ry, Rx <= bus, Done=1, next T0.
  - mvi: bus=DIN, Rx <= bus, Done=1, next T0.
  - mvnz: if Z=0 then bus=Ry and Rx <= bus; if Z=1 then Rx is unchanged and the bus is undriven. Done=1 either way, next T0.
  - add/sub/and/or/xor: bus=Rx, A <= bus, next T2.
- T2 (ALU ops): bus=Ry, G <= A op bus, Z <= (result == 0), next T3.
- T3 (ALU ops): bus=G, Rx <= bus, Done=1, next T0.
- Latency: mv/mvi/mvnz take 2 cycles including T0; ALU ops take 4.
- Done is a Moore output decoded from state and I. It is high for exactly one cycle per instruction and never high in T0.
- Arithmetic is modulo 2^DW with no carry/overflow output. sub is A - bus in two's complement. Logic ops are bitwise over DW.
- X=Y is legal: add R1,R1 doubles R1; sub R1,R1 gives 0 and Z=1.
- Z changes only on G loads in T2. mv, mvi and mvnz leave Z untouched.
- Reset asserted mid-instruction aborts it immediately: all state returns to reset values and there is no partial write after release.
- Run held high continuously: the next instruction is fetched in the T0 that follows Done, giving back-to-back execution with no idle cycle.
- Unused upper DIN bits in T0 have no effect. mvi with DW > 9 loads the full DW-bit DIN value.

Test Plan:
- Reset then mvi R0,5: DIN=0x0040 with Run=1, then DIN=0x0005 in T1. Required: R0=0x0005, Done high for one cycle in T1, bus=0x0005 in T1.
- Load R0=5, R1=3, then add R0,R1 (0x0081). Required: A=5 after T1, G=8 and Z=0 after T2, R0=0x0008 after T3, Done only in T3.
- Load R2=0, R3=1, then sub R2,R3 (0x00D3). Required: R2=0xFFFF, Z=0. Then xor R2,R2 (0x0192): R2=0, Z=1.
- With Z=1, mvnz R4,R5 (0x01E5) where R5=0x1234 and R4=0x0007: R4 stays 0x0007. Then make Z=0 and repeat: R4=0x1234.
- Reset pulse during T2 of an add: R0-R7, A, G = 0 and state=T0 immediately. No write to Rx after release; Done stays 0.
- Run held high across mv R6,R0 then add R6,R6 with R0=0x8001: back-to-back with no idle T0. R6=0x0002 (wrap), Done pulses exactly twice.

Source files
------------

// File: rtl/proc_alu8.sv
// Multicycle bus processor: eight registers, A and G, one multiplexed bus,
// sequenced by a four-step FSM (T0 fetch, T1-T3 execute).
module proc_alu8 #(
    parameter int DW = 16
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          Run,
    input  logic [DW-1:0] DIN,
    output logic          Done,
    output logic [DW-1:0] BusWires,
    output logic          Z
);

    typedef enum logic [1:0] {T0, T1, T2, T3} state_t;
    typedef enum logic [2:0] {SEL_NONE, SEL_RX, SEL_RY, SEL_DIN, SEL_G} bus_sel_t;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_MVNZ = 3'b111;

    state_t          r_state;
    state_t          w_next;
    bus_sel_t        w_sel;
    logic [DW-1:0]   r_regs [8];
    logic [DW-1:0]   r_a;
    logic [DW-1:0]   r_g;
    logic [8:0]      r_ir;
    logic            r_z;
    logic [2:0]      w_i;
    logic [2:0]      w_x;
    logic [2:0]      w_y;
    logic            w_done;
    logic            w_rx_load;
    logic            w_a_load;
    logic            w_g_load;
    logic            w_ir_load;
    logic [DW-1:0]   w_alu;

    assign w_i = r_ir[8:6];
    assign w_x = r_ir[5:3];
    assign w_y = r_ir[2:0];

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) r_state <= T0;
        else         r_state <= w_next;
    end

    // Done and all load enables depend only on state and opcode (plus Z for mvnz writes)
    always_comb begin
        w_next    = r_state;
        w_sel     = SEL_NONE;
        w_done    = 1'b0;
        w_rx_load = 1'b0;
        w_a_load  = 1'b0;
        w_g_load  = 1'b0;
        w_ir_load = 1'b0;
        case (r_state)
            T0: begin
                if (Run) begin
                    w_ir_load = 1'b1;
                    w_next    = T1;
                end
            end
            T1: begin
                case (w_i)
                    OP_MV: begin
                        w_sel = SEL_RY; w_rx_load = 1'b1; w_done = 1'b1; w_next = T0;
                    end
                    OP_MVI: begin
                        w_sel = SEL_DIN; w_rx_load = 1'b1; w_done = 1'b1; w_next = T0;
                    end
                    OP_MVNZ: begin
                        if (!r_z) begin
                            w_sel     = SEL_RY;
                            w_rx_load = 1'b1;
                        end
                        w_done = 1'b1;
                        w_next = T0;
                    end
                    default: begin
                        w_sel = SEL_RX; w_a_load = 1'b1; w_next = T2;
                    end
                endcase
            end
            T2: begin
                w_sel = SEL_RY; w_g_load = 1'b1; w_next = T3;
            end
            T3: begin
                w_sel = SEL_G; w_rx_load = 1'b1; w_done = 1'b1; w_next = T0;
            end
            default: w_next = T0;
        endcase
    end

    always_comb begin
        case (w_sel)
            SEL_RX:  BusWires = r_regs[w_x];
            SEL_RY:  BusWires = r_regs[w_y];
            SEL_DIN: BusWires = DIN;
            SEL_G:   BusWires = r_g;
            default: BusWires = '0;
        endcase
    end

    always_comb begin
        case (w_i)
            OP_ADD:  w_alu = r_a + BusWires;
            OP_SUB:  w_alu = r_a - BusWires;
            OP_AND:  w_alu = r_a & BusWires;
            OP_OR:   w_alu = r_a | BusWires;
            OP_XOR:  w_alu = r_a ^ BusWires;
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int k = 0; k < 8; k++) r_regs[k] <= '0;
            r_a  <= '0;
            r_g  <= '0;
            r_ir <= '0;
            r_z  <= 1'b1;
        end else begin
            if (w_ir_load) r_ir <= DIN[8:0];
            if (w_rx_load) r_regs[w_x] <= BusWires;
            if (w_a_load)  r_a <= BusWires;
            if (w_g_load) begin
                r_g <= w_alu;
                r_z <= (w_alu == '0);
            end
        end
    end

    assign Done = w_done;
    assign Z    = r_z;

endmodule
